// File: rtl/match_vector_gen_if.sv
// ---------------------------------------------------------------------------
// match_vector_gen_if
// Groups the byte-stream handshake and the scan/match-vector outputs of
// match_vector_gen into one bundle.
//
// Signals:
//   in_valid   - producer has a byte on in_data
//   in_ready   - block accepts a byte when in_valid && in_ready
//   in_data    - stream byte
//   scan_start - request a scan of every valid backward offset
//   scan_busy  - scan in progress
//   eq_valid   - equals / eq_offset carry a vector this cycle
//   eq_offset  - backward distance d of the current vector
//   equals     - 17-bit prefix-match vector for offset d
//   scan_done  - single-cycle pulse at the end of a scan
//
// Modports: master = stream producer / vector consumer, slave = the block.
// ---------------------------------------------------------------------------
interface match_vector_gen_if #(
    parameter int HIST_DEPTH = 64,
    parameter int OFF_W      = $clog2(HIST_DEPTH) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             scan_start;
    logic             scan_busy;
    logic             eq_valid;
    logic [OFF_W-1:0] eq_offset;
    logic [16:0]      equals;
    logic             scan_done;

    modport master (
        output in_valid, in_data, scan_start,
        input  in_ready, scan_busy, eq_valid, eq_offset, equals, scan_done
    );

    modport slave (
        input  in_valid, in_data, scan_start,
        output in_ready, scan_busy, eq_valid, eq_offset, equals, scan_done
    );
endinterface

// File: rtl/match_vector_gen.sv
// ---------------------------------------------------------------------------
// match_vector_gen
// Feeds the highest-match priority encoder. Bytes from a stream first fill a
// 16-byte lookahead; once it is full, each new byte pushes the oldest
// lookahead byte into a HIST_DEPTH-byte history ring. A scan walks every
// valid backward offset d = 1..hist_count, one per cycle, and emits a
// registered 17-bit prefix-match vector per offset.
//
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - match_vector_gen_if.slave (stream handshake + scan outputs)
// ---------------------------------------------------------------------------
module match_vector_gen #(
    parameter int HIST_DEPTH = 64,
    parameter int OFF_W      = $clog2(HIST_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    match_vector_gen_if.slave bus
);
    localparam int AW = $clog2(HIST_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [OFF_W-1:0] d_q, d_d;

    logic [7:0]       hist_q [HIST_DEPTH];
    logic [7:0]       la_q   [16];
    logic [4:0]       la_count_q;
    logic [OFF_W-1:0] hist_count_q;
    logic [AW-1:0]    wp_q;

    logic             eq_valid_q;
    logic [OFF_W-1:0] eq_offset_q;
    logic [16:0]      equals_q, equals_d;

    logic             push;
    logic             la_full;
    logic             post_full;
    logic             scan_go;
    logic [OFF_W-1:0] hist_count_post;

    // Bytes are only taken while idle, so a scan always sees frozen storage.
    // The scan trigger looks at post-push counts so that a byte arriving in
    // the same cycle as scan_start is part of the scanned contents.
    always_comb begin
        push            = bus.in_valid && (state_q == IDLE);
        la_full         = (la_count_q == 5'd16);
        post_full       = la_full || (push && (la_count_q == 5'd15));
        scan_go         = (state_q == IDLE) && bus.scan_start && post_full;
        hist_count_post = hist_count_q;
        if (push && la_full && (hist_count_q != OFF_W'(HIST_DEPTH)))
            hist_count_post = hist_count_q + 1'b1;
    end

    // Lookahead / history storage. Array contents are not reset; the counts
    // alone decide what is valid, so clearing them discards the history.
    always_ff @(posedge clk) begin
        if (reset) begin
            la_count_q   <= '0;
            hist_count_q <= '0;
            wp_q         <= '0;
        end else if (push) begin
            if (la_full) begin
                hist_q[wp_q] <= la_q[0];
                wp_q         <= wp_q + 1'b1;
                for (int i = 0; i < 15; i++)
                    la_q[i] <= la_q[i+1];
                la_q[15]     <= bus.in_data;
                hist_count_q <= hist_count_post;
            end else begin
                la_q[la_count_q[3:0]] <= bus.in_data;
                la_count_q            <= la_count_q + 1'b1;
            end
        end
    end

    // FSM state and offset counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
        end
    end

    // Next-state logic: SCAN issues d = 1..hist_count, then one DRAIN cycle
    // lets the last registered vector leave alongside scan_done.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (scan_go) begin
                    if (hist_count_post != '0) begin
                        state_d = SCAN;
                        d_d     = OFF_W'(1);
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            SCAN: begin
                d_d = d_q + 1'b1;
                if (d_q == hist_count_q)
                    state_d = DRAIN;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Prefix-match vector for the current offset. Compared history position
    // i sits d-i bytes behind the write pointer; once i reaches d it would
    // point into the lookahead itself, so the chain is cut there.
    always_comb begin
        equals_d    = '0;
        equals_d[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            equals_d[k] = equals_d[k-1]
                       && (OFF_W'(k - 1) < d_q)
                       && (la_q[k-1] == hist_q[wp_q - d_q[AW-1:0] + AW'(k - 1)]);
        end
    end

    // Registered vector outputs; zero whenever no vector is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            eq_valid_q  <= 1'b0;
            eq_offset_q <= '0;
            equals_q    <= '0;
        end else if (state_q == SCAN) begin
            eq_valid_q  <= 1'b1;
            eq_offset_q <= d_q;
            equals_q    <= equals_d;
        end else begin
            eq_valid_q  <= 1'b0;
            eq_offset_q <= '0;
            equals_q    <= '0;
        end
    end

    // Status outputs follow the state register directly.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.scan_busy = (state_q != IDLE);
    assign bus.scan_done = (state_q == DRAIN);
    assign bus.eq_valid  = eq_valid_q;
    assign bus.eq_offset = eq_offset_q;
    assign bus.equals    = equals_q;
endmodule

// File: doc/match_vector_gen.md
Name: match_vector_gen

Overview:
- Upstream feeder for the highest-match priority encoder.
- Holds a sliding byte history ring plus a 16-byte lookahead register, filled from a byte stream.
- On request, scans every valid backward offset, one per cycle. For each offset it emits a 17-bit prefix-match vector, which the encoder turns into a match length.

Parameters:
- HIST_DEPTH, 64, history ring size in bytes; power of two, at least 16.
- OFF_W, $clog2(HIST_DEPTH)+1, width of eq_offset; must hold HIST_DEPTH.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data holds a byte
- in_ready  output  1  byte accepted when in_valid && in_ready
- in_data  input  8  stream byte
- scan_start  input  1  request a scan of all offsets
- scan_busy  output  1  scan in progress
- eq_valid  output  1  equals/eq_offset valid this cycle
- eq_offset  output  OFF_W  backward distance d of this vector
- equals  output  17  prefix-match vector for offset d; feeds the encoder's equals input
- scan_done  output  1  single-cycle pulse marking end of scan

Behaviour:
- **Clocking and reset:** one clock, reset is synchronous and active-high.
- **Reset values:** all outputs 0 except in_ready=1; la_count=0, hist_count=0, wp=0, state=IDLE.
- **Storage:**
  - la[0..15] holds the lookahead, la[0] oldest; la_count runs 0..16.
  - Accepted byte with la_count<16: appended at la[la_count]; la_count++.
  - Accepted byte with la_count==16: la[0] written to hist[wp]; wp++ (wraps mod HIST_DEPTH); lookahead shifts and the new byte goes to la[15]; hist_count++ saturating at HIST_DEPTH.
- **Handshake:** in_ready = (state==IDLE). No byte is accepted in SCAN or DRAIN.
- **Scan trigger:** in IDLE, scan_start is accepted only if la_count is 16 after this cycle's push; otherwise it is ignored, with no pulse.
  - scan_start in SCAN or DRAIN is ignored.
  - A byte pushed in the same cycle as an accepted scan_start (cycle T) is included in the scanned contents.
- **States:** IDLE, SCAN, DRAIN.
  - IDLE -> SCAN when scan_start is accepted and hist_count>0; the offset counter d is set to 1.
  - IDLE -> DRAIN when scan_start is accepted and hist_count==0.
  - SCAN: d increments each cycle; -> DRAIN after d==hist_count is issued.
  - DRAIN: one cycle, then -> IDLE.
- **Match vector** (hist_idx(d,i) = (wp - d + i) mod HIST_DEPTH, with wp sampled at T):
  - equals[0]=1.
  - For k=1..16: equals[k] = equals[k-1] && (k-1 < d) && la[k-1]==hist[hist_idx(d,k-1)].
  - Positions at or beyond wp, i.e. i>=d, never match.
- **Output timing:** vectors are registered, one cycle after d is issued. For N=hist_count:
  - eq_valid is high T+2..T+N+1, with eq_offset=1..N ascending.
  - scan_done pulses at T+N+1, together with the last eq_valid.
  - scan_busy is high T+1..T+N+1; in_ready is low over the same cycles.
  - When eq_valid=0, equals and eq_offset hold 0.
- **Empty history:** N=0 gives scan_done at T+1, scan_busy high at T+1 only, and no eq_valid.
- **Unchanged by a scan:** history, lookahead and counts.
- **Reset mid-scan:** aborts; next cycle all outputs are at reset values, no scan_done is issued, and the stored history is discarded.

Test Plan:
1. **Reset:** assert reset for 2 cycles -> in_ready=1; eq_valid, scan_busy, scan_done, equals all 0; scan_start with no data gives no response.
2. **Distinct bytes:**
   - Stimulus: push 0x00..0x13 (20 bytes): hist={00..03}, la={04..13}; then scan_start.
   - Response: 4 eq_valid cycles, eq_offset 1,2,3,4, each equals=17'h00001; scan_done on the 4th; in_ready=1 the following cycle.
3. **Uniform data:**
   - Stimulus: push 48 bytes of 0xAA (hist_count=32); scan.
   - Response: d=1 -> 17'h00003; d=2 -> 17'h00007; d=15 -> 17'h0FFFF; d>=16 -> 17'h1FFFF through d=32; 32 eq_valid cycles.
4. **Wrap and saturation:**
   - Stimulus: push 90 bytes, value = index mod 64; scan.
   - Response: hist_count=64, so 64 eq_valid cycles; d=64 -> 17'h1FFFF; d=1..63 -> 17'h00001.
5. **Ignored requests:**
   - scan_start with 15 bytes pushed -> no busy/done.
   - scan_start and in_valid held high during a scan -> no byte accepted (in_ready=0) and no rescan.
   - Push of the 16th byte in the same cycle as scan_start -> scan runs on the post-push contents: with 16 bytes total hist_count=0, so scan_done at T+1 with no eq_valid.
6. **Reset mid-scan:** assert reset during the 3rd eq_valid of test 2 -> next cycle eq_valid=0, scan_busy=0, no scan_done ever, in_ready=1; a subsequent scan_start with la_count=0 is ignored.
